// File: rtl/cache_pkg.sv
// Shared types and width helpers for the n-way write-back cache controller.
package cache_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLookup,
    StWback,
    StRefill,
    StRespond
  } cache_state_t;

  // Widest tag the metadata struct can carry; real tags are zero-extended into it.
  localparam int unsigned MAX_TAG_W = 64;

  typedef struct packed {
    logic                 valid;
    logic                 dirty;
    logic [MAX_TAG_W-1:0] tag;
  } line_meta_t;

  function automatic int unsigned off_w(input int unsigned data_w);
    return $clog2(data_w / 8);
  endfunction

  function automatic int unsigned tag_w(input int unsigned addr_w, input int unsigned index_w,
                                        input int unsigned data_w);
    return addr_w - index_w - off_w(data_w);
  endfunction

endpackage

// File: rtl/cache_ctrl_nway_if.sv
// CPU-side and memory-side handshake bundle of the n-way cache controller.
interface cache_ctrl_nway_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic                  cpu_req;
  logic                  cpu_we;
  logic [ADDR_W-1:0]     cpu_addr;
  logic [DATA_W-1:0]     cpu_wdata;
  logic [DATA_W/8-1:0]   cpu_be;
  logic [DATA_W-1:0]     cpu_rdata;
  logic                  cpu_ack;
  logic                  cpu_hit;
  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_W-1:0]     mem_addr;
  logic [DATA_W-1:0]     mem_wdata;
  logic [DATA_W-1:0]     mem_rdata;
  logic                  mem_ack;

  // Cache side.
  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_be, mem_rdata, mem_ack,
    output cpu_rdata, cpu_ack, cpu_hit, mem_req, mem_we, mem_addr, mem_wdata
  );

  // CPU plus main-memory side.
  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_be, mem_rdata, mem_ack,
    input  cpu_rdata, cpu_ack, cpu_hit, mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/cache_way_array.sv
// One way of cache storage: valid/dirty/tag/data per set, combinational read, byte-merging write.
module cache_way_array
  import cache_pkg::*;
#(
  parameter int unsigned INDEX_W = 8,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TAG_W   = 22
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [INDEX_W-1:0]  rd_idx,
  output line_meta_t          rd_meta,
  output logic [DATA_W-1:0]   rd_data,
  input  logic                wr_en,
  input  logic [INDEX_W-1:0]  wr_idx,
  input  logic [TAG_W-1:0]    wr_tag,
  input  logic                wr_dirty,
  input  logic [DATA_W-1:0]   wr_base,
  input  logic [DATA_W-1:0]   wr_merge,
  input  logic [DATA_W/8-1:0] wr_be
);
  localparam int unsigned SETS = 2 ** INDEX_W;
  localparam int unsigned NB   = DATA_W / 8;

  logic [SETS-1:0]   valid_q, dirty_q;
  logic [TAG_W-1:0]  tag_q  [SETS];
  logic [DATA_W-1:0] data_q [SETS];
  logic [DATA_W-1:0] wr_word;

  always_comb begin
    wr_word = wr_base;
    for (int b = 0; b < NB; b++) begin
      if (wr_be[b]) wr_word[8*b +: 8] = wr_merge[8*b +: 8];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (wr_en) begin
      valid_q[wr_idx] <= 1'b1;
      dirty_q[wr_idx] <= wr_dirty;
    end
  end

  // Tag and data are qualified by valid, so they need no reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_q[wr_idx]  <= wr_tag;
      data_q[wr_idx] <= wr_word;
    end
  end

  always_comb begin
    rd_meta       = '0;
    rd_meta.valid = valid_q[rd_idx];
    rd_meta.dirty = dirty_q[rd_idx];
    rd_meta.tag   = MAX_TAG_W'(tag_q[rd_idx]);
    rd_data       = data_q[rd_idx];
  end

endmodule

// File: rtl/cache_ctrl_nway.sv
// Write-back, write-allocate set-associative cache controller (1 or 2 ways, per-set LRU).
// Define CACHE_STATS_EN to build the hit/miss counters; otherwise they read as 0.
module cache_ctrl_nway
  import cache_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned INDEX_W = 8,
  parameter int unsigned WAYS    = 2
) (
  input  logic              clk,
  input  logic              rst,
  cache_ctrl_nway_if.slave  bus,
  output logic [31:0]       stat_hits,
  output logic [31:0]       stat_misses
);
  localparam int unsigned OFF_W  = off_w(DATA_W);
  localparam int unsigned TAG_W  = tag_w(ADDR_W, INDEX_W, DATA_W);
  localparam int unsigned LINE_W = ADDR_W - OFF_W;
  localparam int unsigned SETS   = 2 ** INDEX_W;
  localparam int unsigned NB     = DATA_W / 8;

  cache_state_t      state_q, state_d;
  logic [LINE_W-1:0] line_q;
  logic              we_q, hit_q, victim_q;
  logic [DATA_W-1:0] wdata_q, rdata_q;
  logic [NB-1:0]     be_q;
  logic [SETS-1:0]   lru_q;
  logic              mem_req_q, mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;

  logic [INDEX_W-1:0] idx;
  logic [TAG_W-1:0]   req_tag;
  line_meta_t         meta    [WAYS];
  logic [DATA_W-1:0]  rd_data [WAYS];
  logic [WAYS-1:0]    hit_vec, wr_en;
  logic               hit_any, hit_way, vict, vict_found, vict_dirty;
  logic               wr_dirty;
  logic [DATA_W-1:0]  wr_base;
  logic [NB-1:0]      wr_be;
  logic [ADDR_W-1:0]  req_line_addr, vict_line_addr;

  assign idx           = line_q[INDEX_W-1:0];
  assign req_tag       = line_q[LINE_W-1 -: TAG_W];
  assign req_line_addr = ADDR_W'(line_q) << OFF_W;

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    cache_way_array #(
      .INDEX_W (INDEX_W),
      .DATA_W  (DATA_W),
      .TAG_W   (TAG_W)
    ) u_way (
      .clk      (clk),
      .rst      (rst),
      .rd_idx   (idx),
      .rd_meta  (meta[w]),
      .rd_data  (rd_data[w]),
      .wr_en    (wr_en[w]),
      .wr_idx   (idx),
      .wr_tag   (req_tag),
      .wr_dirty (wr_dirty),
      .wr_base  (wr_base),
      .wr_merge (wdata_q),
      .wr_be    (wr_be)
    );
  end

  always_comb begin
    hit_way    = 1'b0;
    vict       = lru_q[idx];
    vict_found = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      hit_vec[w] = meta[w].valid && (meta[w].tag == MAX_TAG_W'(req_tag));
      if (hit_vec[w]) hit_way = 1'(w);
      if (!meta[w].valid && !vict_found) begin
        vict       = 1'(w);
        vict_found = 1'b1;
      end
    end
    hit_any        = |hit_vec;
    vict_dirty     = meta[vict].valid && meta[vict].dirty;
    vict_line_addr = (ADDR_W'(meta[vict].tag) << (INDEX_W + OFF_W)) | (ADDR_W'(idx) << OFF_W);
  end

  always_comb begin
    state_d  = state_q;
    wr_en    = '0;
    wr_base  = rd_data[hit_way];
    wr_be    = be_q;
    wr_dirty = 1'b1;
    unique case (state_q)
      StIdle:   if (bus.cpu_req) state_d = StLookup;
      StLookup: begin
        if (hit_any) begin
          if (we_q) wr_en[hit_way] = 1'b1;
          state_d = StRespond;
        end else begin
          state_d = vict_dirty ? StWback : StRefill;
        end
      end
      StWback:  if (bus.mem_ack) state_d = StRefill;
      StRefill: begin
        if (bus.mem_ack) begin
          wr_en[victim_q] = 1'b1;
          wr_base         = bus.mem_rdata;
          wr_be           = we_q ? be_q : '0;
          wr_dirty        = we_q;
          state_d         = StRespond;
        end
      end
      StRespond: state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      line_q      <= '0;
      we_q        <= 1'b0;
      wdata_q     <= '0;
      be_q        <= '0;
      hit_q       <= 1'b0;
      victim_q    <= 1'b0;
      rdata_q     <= '0;
      lru_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        StIdle: begin
          if (bus.cpu_req) begin
            line_q  <= bus.cpu_addr[ADDR_W-1:OFF_W];
            we_q    <= bus.cpu_we;
            wdata_q <= bus.cpu_wdata;
            be_q    <= bus.cpu_be;
          end
        end
        StLookup: begin
          if (hit_any) begin
            hit_q      <= 1'b1;
            rdata_q    <= rd_data[hit_way];
            lru_q[idx] <= (WAYS > 1) ? ~hit_way : 1'b0;
          end else begin
            hit_q     <= 1'b0;
            victim_q  <= vict;
            mem_req_q <= 1'b1;
            mem_we_q  <= vict_dirty;
            if (vict_dirty) begin
              mem_addr_q  <= vict_line_addr;
              mem_wdata_q <= rd_data[vict];
            end else begin
              mem_addr_q <= req_line_addr;
            end
          end
        end
        StWback: begin
          if (bus.mem_ack) begin
            mem_we_q   <= 1'b0;
            mem_addr_q <= req_line_addr;
          end
        end
        StRefill: begin
          if (bus.mem_ack) begin
            mem_req_q  <= 1'b0;
            rdata_q    <= bus.mem_rdata;
            lru_q[idx] <= (WAYS > 1) ? ~victim_q : 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.cpu_ack   = (state_q == StRespond);
  assign bus.cpu_hit   = (state_q == StRespond) && hit_q;
  assign bus.cpu_rdata = rdata_q;
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;

`ifdef CACHE_STATS_EN
  logic [31:0] hits_q, misses_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hits_q   <= '0;
      misses_q <= '0;
    end else if (state_q == StRespond) begin
      if (hit_q) hits_q   <= hits_q + 32'd1;
      else       misses_q <= misses_q + 32'd1;
    end
  end

  assign stat_hits   = hits_q;
  assign stat_misses = misses_q;
`else
  assign stat_hits   = '0;
  assign stat_misses = '0;
`endif

endmodule

// File: tb/tb_cache_ctrl_nway.sv
// Self-checking bench: directed scenarios plus random traffic against an LRU/golden-memory model.
module tb_cache_ctrl_nway;

  logic clk = 1'b0;
  logic rst;
  logic [31:0] stat_hits, stat_misses;

  always #5 clk = ~clk;

  cache_ctrl_nway_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  cache_ctrl_nway #(
    .ADDR_W  (32),
    .DATA_W  (32),
    .INDEX_W (8),
    .WAYS    (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .stat_hits   (stat_hits),
    .stat_misses (stat_misses)
  );

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Main memory as seen by the DUT, and the architectural memory as the CPU should see it.
  logic [31:0] backing [logic [31:0]];
  logic [31:0] golden  [logic [31:0]];
  int unsigned rf_cnt = 0, wb_cnt = 0;
  logic [31:0] last_wb_addr, last_wb_data, last_rf_addr;

  function automatic logic [31:0] init_val(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  function automatic logic [31:0] mem_val(input logic [31:0] a);
    return backing.exists(a) ? backing[a] : init_val(a);
  endfunction

  function automatic logic [31:0] gold_val(input logic [31:0] a);
    return golden.exists(a) ? golden[a] : init_val(a);
  endfunction

  // Memory responder: ack three cycles after a request is first seen.
  initial begin : mem_model
    int lat;
    bit pending;
    pending = 0;
    lat = 0;
    bus.mem_ack = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      bus.mem_ack = 1'b0;
      if (bus.mem_req && !rst) begin
        if (!pending) begin
          pending = 1;
          lat = 0;
        end
        lat++;
        if (lat == 3) begin
          pending = 0;
          bus.mem_ack = 1'b1;
          if (bus.mem_we) begin
            backing[bus.mem_addr] = bus.mem_wdata;
            last_wb_addr = bus.mem_addr;
            last_wb_data = bus.mem_wdata;
            wb_cnt++;
          end else begin
            bus.mem_rdata = mem_val(bus.mem_addr);
            last_rf_addr = bus.mem_addr;
            rf_cnt++;
          end
        end
      end else begin
        pending = 0;
      end
    end
  end

  // Reference cache: per set, resident line addresses in recency order (front = most recent).
  logic [31:0] sets_m [256][$];
  bit          dirty_m [logic [31:0]];
  int unsigned hits_m = 0, misses_m = 0;

  task automatic reset_model();
    for (int s = 0; s < 256; s++) sets_m[s].delete();
    dirty_m.delete();
    golden = backing;
    hits_m = 0;
    misses_m = 0;
  endtask

  task automatic check_stats();
`ifdef CACHE_STATS_EN
    check_eq("stat_hits", 64'(stat_hits), 64'(hits_m));
    check_eq("stat_misses", 64'(stat_misses), 64'(misses_m));
`else
    check_eq("stat_hits", 64'(stat_hits), 64'd0);
    check_eq("stat_misses", 64'(stat_misses), 64'd0);
`endif
  endtask

  task automatic do_txn(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] be, output logic [31:0] rd_o, output bit hit_o);
    logic [31:0] la, wb_a, wb_d, exp_rd, g;
    int s, pos, cyc;
    bit exp_hit, exp_wb, got;
    int unsigned rf0, wb0;
    la = addr & ~32'h3;
    s = int'((addr >> 2) & 32'hFF);
    pos = -1;
    for (int i = 0; i < sets_m[s].size(); i++) if (sets_m[s][i] == la) pos = i;
    exp_hit = (pos >= 0);
    exp_wb = 0;
    wb_a = '0;
    wb_d = '0;
    exp_rd = gold_val(la);
    if (exp_hit) begin
      sets_m[s].delete(pos);
      hits_m++;
    end else begin
      misses_m++;
      if (sets_m[s].size() == 2) begin
        wb_a = sets_m[s].pop_back();
        exp_wb = dirty_m.exists(wb_a);
        wb_d = gold_val(wb_a);
        if (exp_wb) dirty_m.delete(wb_a);
      end
    end
    sets_m[s].push_front(la);
    if (we) begin
      g = exp_rd;
      for (int b = 0; b < 4; b++) if (be[b]) g[8*b +: 8] = wdata[8*b +: 8];
      golden[la] = g;
      dirty_m[la] = 1;
    end

    @(negedge clk);
    rf0 = rf_cnt;
    wb0 = wb_cnt;
    bus.cpu_req = 1'b1;
    bus.cpu_we = we;
    bus.cpu_addr = addr;
    bus.cpu_wdata = wdata;
    bus.cpu_be = be;
    cyc = 0;
    got = 0;
    while (!got && cyc < 200) begin
      @(posedge clk);
      #1;
      cyc++;
      if (bus.cpu_ack) got = 1;
    end
    rd_o = bus.cpu_rdata;
    hit_o = bus.cpu_hit;
    if (!got) begin
      check_eq("ack_timeout", 64'd0, 64'd1);
      bus.cpu_req = 1'b0;
      return;
    end
    check_eq("hit", 64'(bus.cpu_hit), 64'(exp_hit));
    if (!we) check_eq("rdata", 64'(bus.cpu_rdata), 64'(exp_rd));
    if (exp_hit) check_eq("hit_latency", 64'(cyc), 64'd2);
    check_eq("refills", 64'(rf_cnt - rf0), 64'(!exp_hit));
    check_eq("writebacks", 64'(wb_cnt - wb0), 64'(exp_wb));
    if (!exp_hit) check_eq("refill_addr", 64'(last_rf_addr), 64'(la));
    if (exp_wb) begin
      check_eq("wb_addr", 64'(last_wb_addr), 64'(wb_a));
      check_eq("wb_data", 64'(last_wb_data), 64'(wb_d));
    end
    @(negedge clk);
    bus.cpu_req = 1'b0;
    @(posedge clk);
    #1;
    check_stats();
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog simulation did not finish, checks %0d", checks);
    $fatal(1);
  end

  initial begin : main
    logic [31:0] rd;
    bit hit, found;
    rst = 1'b1;
    bus.cpu_req = 1'b0;
    bus.cpu_we = 1'b0;
    bus.cpu_addr = '0;
    bus.cpu_wdata = '0;
    bus.cpu_be = '0;
    backing[32'h10] = 32'hDEAD_BEEF;
    golden = backing;

    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_cpu_ack", 64'(bus.cpu_ack), 64'd0);
    check_eq("rst_cpu_hit", 64'(bus.cpu_hit), 64'd0);
    check_eq("rst_cpu_rdata", 64'(bus.cpu_rdata), 64'd0);
    check_eq("rst_mem_req", 64'(bus.mem_req), 64'd0);
    check_eq("rst_mem_addr", 64'(bus.mem_addr), 64'd0);
    check_eq("rst_stat_hits", 64'(stat_hits), 64'd0);
    check_eq("rst_stat_misses", 64'(stat_misses), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Cold read then re-read.
    do_txn(0, 32'h10, '0, '0, rd, hit);
    check_eq("s1_cold_rdata", 64'(rd), 64'hDEAD_BEEF);
    do_txn(0, 32'h10, '0, '0, rd, hit);
    check_eq("s1_rehit", 64'(hit), 64'd1);

    // Byte-enabled write hit.
    do_txn(1, 32'h10, 32'h1122_3344, 4'b0011, rd, hit);
    check_eq("s2_write_hit", 64'(hit), 64'd1);
    do_txn(0, 32'h10, '0, '0, rd, hit);
    check_eq("s2_merged", 64'(rd), 64'hDEAD_3344);

    // Fill both ways of one set, then evictions driven by LRU.
    do_txn(0, 32'h10, '0, '0, rd, hit);
    do_txn(0, 32'h410, '0, '0, rd, hit);
    do_txn(0, 32'h10, '0, '0, rd, hit);
    check_eq("s3_both_resident", 64'(hit), 64'd1);
    do_txn(0, 32'h810, '0, '0, rd, hit);
    do_txn(0, 32'h10, '0, '0, rd, hit);
    do_txn(0, 32'hC10, '0, '0, rd, hit);
    do_txn(0, 32'h410, '0, '0, rd, hit);
    do_txn(0, 32'h10, '0, '0, rd, hit);
    check_eq("s4_evicted_miss", 64'(hit), 64'd0);

    // Reset while a dirty victim is being written back.
    do_txn(1, 32'h20, 32'hCAFE_F00D, 4'b1111, rd, hit);
    do_txn(0, 32'h420, '0, '0, rd, hit);
    @(negedge clk);
    bus.cpu_req = 1'b1;
    bus.cpu_we = 1'b0;
    bus.cpu_addr = 32'h820;
    found = 0;
    for (int c = 0; c < 50 && !found; c++) begin
      @(negedge clk);
      if (bus.mem_req && bus.mem_we) found = 1;
    end
    check_eq("s5_wback_seen", 64'(found), 64'd1);
    rst = 1'b1;
    bus.cpu_req = 1'b0;
    #1;
    check_eq("s5_mem_req_drop", 64'(bus.mem_req), 64'd0);
    check_eq("s5_no_ack", 64'(bus.cpu_ack), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    check_eq("s5_no_ack_held", 64'(bus.cpu_ack), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    reset_model();
    do_txn(0, 32'h10, '0, '0, rd, hit);
    check_eq("s5_post_reset_miss", 64'(hit), 64'd0);
    do_txn(0, 32'h20, '0, '0, rd, hit);

    // Random traffic over a few tags and sets to exercise hits, evictions and write-backs.
    for (int n = 0; n < 300; n++) begin
      logic [31:0] a;
      a = (32'($urandom_range(0, 3)) << 10) | (32'($urandom_range(0, 7)) << 2)
          | 32'($urandom_range(0, 3));
      do_txn(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)), rd, hit);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
